// File: rtl/top_lut2_pkg.sv
// ============================================================================
// Module   : top_lut2_pkg
// Brief    : Shared constants, types and LUT evaluation helper for the
//            configurable 2-input logic cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package top_lut2_pkg;

  localparam int LUT_W = 4;

  typedef logic [LUT_W-1:0] lut2_cfg_t;

  localparam lut2_cfg_t LUT_AND  = 4'b1000;
  localparam lut2_cfg_t LUT_OR   = 4'b1110;
  localparam lut2_cfg_t LUT_XOR  = 4'b0110;
  localparam lut2_cfg_t LUT_NAND = 4'b0111;

  // Truth-table lookup; a is the index LSB, b the MSB.
  function automatic logic lut2_eval(input lut2_cfg_t table_bits, input logic a,
                                     input logic b);
    return table_bits[{b, a}];
  endfunction

endpackage

`default_nettype wire

// File: rtl/top_lut2_cell_if.sv
// ============================================================================
// Module   : top_lut2_cell_if
// Brief    : Data and configuration-chain signals of the 2-input logic cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface top_lut2_cell_if;
  logic a;
  logic b;
  logic cfg_en;
  logic cfg_in;
  logic c;
  logic cfg_out;

  modport master (
    output a, b, cfg_en, cfg_in,
    input  c, cfg_out
  );

  modport slave (
    input  a, b, cfg_en, cfg_in,
    output c, cfg_out
  );
endinterface

`default_nettype wire

// File: rtl/top_lut2_ccff.sv
// ============================================================================
// Module   : top_lut2_ccff
// Brief    : 4-bit serial configuration chain register, resets to LUT_INIT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_lut2_ccff
  import top_lut2_pkg::*;
#(
  parameter lut2_cfg_t LUT_INIT = LUT_AND
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_shift_en,
  input  wire logic i_shift_in,
  output lut2_cfg_t o_cfg
);

  lut2_cfg_t r_cfg;

  // MSB-first loading: the first bit entered reaches bit 3 after four shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg <= LUT_INIT;
    end else if (i_shift_en) begin
      r_cfg <= {r_cfg[LUT_W-2:0], i_shift_in};
    end
  end

  assign o_cfg = r_cfg;

endmodule

`default_nettype wire

// File: rtl/top_lut2_cell.sv
// ============================================================================
// Module   : top_lut2_cell
// Brief    : Configurable 2-input LUT cell with scan-loadable truth table and
//            optional registered output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_lut2_cell
  import top_lut2_pkg::*;
#(
  parameter lut2_cfg_t LUT_INIT   = LUT_AND,
  parameter bit        REGISTERED = 1'b0
) (
  input wire logic        clk,
  input wire logic        rst_n,
  top_lut2_cell_if.slave  bus
);

  lut2_cfg_t w_cfg;
  logic      w_lut_out;

  top_lut2_ccff #(
    .LUT_INIT (LUT_INIT)
  ) u_ccff (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_shift_en (bus.cfg_en),
    .i_shift_in (bus.cfg_in),
    .o_cfg      (w_cfg)
  );

  assign w_lut_out   = lut2_eval(w_cfg, bus.a, bus.b);
  assign bus.cfg_out = w_cfg[LUT_W-1];

  generate
    if (REGISTERED) begin : g_reg_out
      logic r_q;

      // Output flop freezes while the table is being shifted.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= 1'b0;
        end else if (!bus.cfg_en) begin
          r_q <= w_lut_out;
        end
      end

      assign bus.c = r_q;
    end else begin : g_comb_out
      assign bus.c = w_lut_out;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_top_lut2_cell.sv
// ============================================================================
// Module   : tb_top_lut2_cell
// Brief    : Self-checking bench driving a combinational and a registered cell
//            in lockstep against an arithmetic truth-table model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top_lut2_cell;
  import top_lut2_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  top_lut2_cell_if if_c ();
  top_lut2_cell_if if_r ();

  top_lut2_cell #(.LUT_INIT(LUT_AND), .REGISTERED(1'b0)) u_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_c.slave)
  );

  top_lut2_cell #(.LUT_INIT(LUT_AND), .REGISTERED(1'b1)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_r.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: truth table as an integer 0..15, output flop as 0/1.
  int m_tbl;
  int m_q;

  function automatic int m_lut(input int a, input int b);
    return (m_tbl >> (2 * b + a)) % 2;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit a, input bit b, input bit en, input bit din);
    if_c.a = a; if_c.b = b; if_c.cfg_en = en; if_c.cfg_in = din;
    if_r.a = a; if_r.b = b; if_r.cfg_en = en; if_r.cfg_in = din;
  endtask

  // Apply inputs, cross one rising edge, compare both cells on the falling edge.
  task automatic cycle(input bit a, input bit b, input bit en, input bit din);
    drive(a, b, en, din);
    #1;
    check("comb_same_cycle", {3'b0, if_c.c}, 4'(m_lut(a, b)));
    @(posedge clk);
    if (en) m_tbl = (m_tbl * 2 + din) % 16;
    else    m_q   = m_lut(a, b);
    @(negedge clk);
    check("comb_c", {3'b0, if_c.c}, 4'(m_lut(a, b)));
    check("reg_c", {3'b0, if_r.c}, 4'(m_q));
    check("cfg_out_comb", {3'b0, if_c.cfg_out}, 4'(m_tbl / 8));
    check("cfg_out_reg", {3'b0, if_r.cfg_out}, 4'(m_tbl / 8));
  endtask

  int exp_and[4] = '{0, 0, 0, 1};
  int exp_xor[4] = '{0, 1, 1, 0};
  int xor_bits[4] = '{0, 1, 1, 0};

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    m_tbl = 8;
    m_q   = 0;
    @(negedge clk);
    check("rst_reg_c", {3'b0, if_r.c}, 4'h0);
    check("rst_cfg_out", {3'b0, if_c.cfg_out}, 4'h1);
    check("rst_comb_c", {3'b0, if_c.c}, 4'h0);
    rst_n = 1'b1;

    // Exhaustive inputs with the reset table (AND).
    for (int i = 0; i < 4; i++) begin
      cycle(i[1], i[0], 0, 0);
      check("t1_and", {3'b0, if_c.c}, 4'(exp_and[i]));
    end

    // Asynchronous reset drops the registered output between edges.
    cycle(1, 1, 0, 0);
    check("t2_reg_before", {3'b0, if_r.c}, 4'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t2_async_reg_c", {3'b0, if_r.c}, 4'h0);
    check("t2_async_comb_c", {3'b0, if_c.c}, 4'h1);
    m_tbl = 8;
    m_q   = 0;
    rst_n = 1'b1;
    cycle(1, 1, 0, 0);
    check("t2_reg_after", {3'b0, if_r.c}, 4'h1);

    // Registered latency: input change after an edge shows only at the next.
    @(posedge clk);
    m_q = m_lut(1, 1);
    #1 drive(0, 1, 0, 0);
    @(negedge clk);
    check("t4_reg_hold", {3'b0, if_r.c}, 4'h1);
    @(posedge clk);
    m_q = m_lut(0, 1);
    @(negedge clk);
    check("t4_reg_update", {3'b0, if_r.c}, 4'h0);

    // Reconfigure to XOR, exercise it, then read the table back serially.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, xor_bits[i][0]);
    for (int i = 0; i < 4; i++) begin
      cycle(i[1], i[0], 0, 0);
      check("t3_xor", {3'b0, if_c.c}, 4'(exp_xor[i]));
    end
    for (int i = 0; i < 4; i++) begin
      check("t3_readback", {3'b0, if_c.cfg_out}, 4'(exp_xor[i]));
      cycle(0, 0, 1, 0);
    end

    // Reset mid-shift discards the partial load.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_tbl = 8;
    m_q   = 0;
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    drive(1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_cfg_out_restored", {3'b0, if_c.cfg_out}, 4'h1);
    check("t5_comb_restored", {3'b0, if_c.c}, 4'h1);
    m_tbl = 8;
    m_q   = 0;
    rst_n = 1'b1;
    cycle(1, 1, 0, 0);
    check("t5_and_11", {3'b0, if_c.c}, 4'h1);
    cycle(1, 0, 0, 0);
    check("t5_and_10", {3'b0, if_c.c}, 4'h0);

    // Random regression with the AND table.
    for (int i = 0; i < 1000; i++) begin
      cycle(1'($urandom), 1'($urandom), 0, 0);
    end

    // Random regression with random table reloads interleaved.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom), 1'($urandom), ($urandom % 4) == 0, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
